// File: rtl/dht_reader.sv
// DHT11/DHT22 single-wire reader: host start pulse, response handshake, 40-bit decode.
// Optional checksum verification is enabled by defining DHT_CHECKSUM_EN.
module dht_reader #(
  parameter int CLK_HZ        = 50000000,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dht_in,
  output logic        dht_oe,
  output logic [39:0] data_out,
  output logic        valid,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_checksum
);

  localparam int DIV    = (CLK_HZ / 1000000 < 1) ? 1 : CLK_HZ / 1000000;
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int US_M0  = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int US_MAX = (US_M0 > BIT_THRESH_US) ? US_M0 : BIT_THRESH_US;
  localparam int US_W   = $clog2(US_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
  } state_t;

  state_t            state;
  logic              sync_p0, sync_p1, line_p2;
  logic              rise, fall, edge_seen, tick, timed_out;
  logic [DIV_W-1:0]  div_cnt;
  logic [US_W-1:0]   us_cnt;
  logic [5:0]        bit_cnt;
  logic [39:0]       shift_reg;

`ifdef DHT_CHECKSUM_EN
  function automatic logic checksum_ok(input logic [39:0] f);
    logic [7:0] sum;
    sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return sum == f[7:0];
  endfunction
`else
  assign err_checksum = 1'b0;
`endif

  // Synchronizer stages p0/p1; p2 holds the previous synchronized level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      line_p2 <= 1'b1;
    end else begin
      sync_p0 <= dht_in;
      sync_p1 <= sync_p0;
      line_p2 <= sync_p1;
    end
  end

  // Edge-based waits ignore the stale low left over from the host start pulse
  assign rise      = sync_p1 & ~line_p2;
  assign fall      = ~sync_p1 & line_p2;
  assign tick      = (div_cnt == DIV_W'(DIV - 1));
  assign timed_out = tick && (us_cnt == US_W'(TIMEOUT_US - 1));

  always_comb begin
    edge_seen = 1'b0;
    case (state)
      RELEASE, RESP_HIGH, BIT_HIGH: edge_seen = fall;
      RESP_LOW, BIT_LOW:            edge_seen = rise;
      default:                      edge_seen = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dht_oe      <= 1'b0;
      data_out    <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
`ifdef DHT_CHECKSUM_EN
      err_checksum <= 1'b0;
`endif
      div_cnt     <= '0;
      us_cnt      <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
    end else begin
      valid <= 1'b0;
      if (tick) begin
        div_cnt <= '0;
        us_cnt  <= us_cnt + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= START_LOW;
            busy        <= 1'b1;
            dht_oe      <= 1'b1;
            err_timeout <= 1'b0;
`ifdef DHT_CHECKSUM_EN
            err_checksum <= 1'b0;
`endif
            div_cnt     <= '0;
            us_cnt      <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
          end
        end
        START_LOW: begin
          if (tick && us_cnt == US_W'(START_LOW_US - 1)) begin
            dht_oe  <= 1'b0;
            state   <= RELEASE;
            div_cnt <= '0;
            us_cnt  <= '0;
          end
        end
        RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH: begin
          if (edge_seen) begin
            div_cnt <= '0;
            us_cnt  <= '0;
            case (state)
              RELEASE:   state <= RESP_LOW;
              RESP_LOW:  state <= RESP_HIGH;
              RESP_HIGH: begin
                state   <= BIT_LOW;
                bit_cnt <= '0;
              end
              BIT_LOW:   state <= BIT_HIGH;
              default: begin
                // us_cnt holds (high cycles - 1) in ticks, so >= threshold means strictly longer
                shift_reg <= {shift_reg[38:0], (us_cnt >= US_W'(BIT_THRESH_US))};
                bit_cnt   <= bit_cnt + 1'b1;
                state     <= (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
              end
            endcase
          end else if (timed_out) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        CHECK: begin
          busy  <= 1'b0;
          state <= IDLE;
`ifdef DHT_CHECKSUM_EN
          if (checksum_ok(shift_reg)) begin
            data_out <= shift_reg;
            valid    <= 1'b1;
          end else begin
            err_checksum <= 1'b1;
          end
`else
          data_out <= shift_reg;
          valid    <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dht_reader.md
DHT_READER -- requirements
Module: dht_reader

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz; 1 us tick = CLK_HZ/1000000 cycles.
REQ-002 SHALL have parameter START_LOW_US, default 18000, host start pulse low time in us.
REQ-003 SHALL have parameter TIMEOUT_US, default 200, maximum wait for any expected line edge in us.
REQ-004 SHALL have parameter BIT_THRESH_US, default 40, high-time threshold in us above which a bit decodes as 1.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a measurement.
REQ-008 SHALL have port dht_in  input  1  raw sensor data line level, asynchronous to clk.
REQ-009 SHALL have port dht_oe  output  1  1 = drive line low; 0 = release the line (external pull-up).
REQ-010 SHALL have port data_out  output  40  last good frame {hum_int, hum_dec, temp_int, temp_dec, checksum}, MSB first; feeds the memory block's DHT input word.
REQ-011 SHALL have port valid  output  1  one-cycle pulse when data_out has just been updated.
REQ-012 SHALL have port busy  output  1  high from start acceptance until return to IDLE.
REQ-013 SHALL have port err_timeout  output  1  sticky; set on any edge timeout, cleared by the next accepted start.
REQ-014 SHALL have port err_checksum  output  1  sticky; set on checksum mismatch, cleared by the next accepted start.

Function
REQ-015 SHALL pass dht_in through a 2-flop synchronizer; all decoding uses the synchronized level only.
REQ-016 SHALL implement states IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK.
REQ-017 IDLE: start=1 SHALL enter START_LOW, assert busy, clear both error flags; start is ignored in all other states.
REQ-018 START_LOW: dht_oe=1 for exactly START_LOW_US us, then dht_oe=0 and enter RELEASE.
REQ-019 RELEASE: wait for line low -> RESP_LOW; RESP_LOW: wait for high -> RESP_HIGH; RESP_HIGH: wait for low -> BIT_LOW with bit counter = 0.
REQ-020 BIT_LOW: wait for high -> BIT_HIGH with us counter cleared; BIT_HIGH: on low, shift in (high time > BIT_THRESH_US ? 1 : 0) into a 40-bit shift register, increment bit counter.
REQ-021 After the 40th bit is shifted, SHALL enter CHECK without waiting for further edges.
REQ-022 CHECK: computed sum = (byte4+byte3+byte2+byte1) mod 256 (bytes 4..1 = bits 39..8); match SHALL load data_out and pulse valid one cycle later, then IDLE.
REQ-023 Any waiting state (RELEASE through BIT_HIGH) exceeding TIMEOUT_US us without the expected edge SHALL set err_timeout and return to IDLE with data_out unchanged.
REQ-024 data_out SHALL change only on a successful frame, never during reception or on error.
REQ-025 busy SHALL deassert in the same cycle the state returns to IDLE; valid and busy-deassert coincide on success.
REQ-026 start asserted in the same cycle as a return to IDLE SHALL be ignored (accepted only when state is IDLE at the clock edge).

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, dht_oe=0, data_out=0, valid=0, busy=0, err_timeout=0, err_checksum=0, counters and shift register 0, synchronizer flops 1.
REQ-028 rst asserted mid-frame SHALL abort the frame with no valid pulse; operation resumes only on a new start after rst deasserts.

Configuration
REQ-029 Macro DHT_CHECKSUM_EN defined: CHECK SHALL compare checksum as in REQ-022; mismatch sets err_checksum, returns to IDLE, no valid, data_out unchanged.
REQ-030 Macro DHT_CHECKSUM_EN undefined: every complete 40-bit frame SHALL load data_out and pulse valid; err_checksum tied 0; no adder logic.

Verification
REQ-031 Sensor model sends 0x37_00_19_00_50 after start -> dht_oe low 18000 us, then valid pulse once, data_out=0x3700190050, both errors 0.
REQ-032 Sensor model never responds after release -> err_timeout=1 at 200 us after release, busy=0, no valid, data_out holds prior value.
REQ-033 With DHT_CHECKSUM_EN, frame 0x37_00_19_00_51 -> err_checksum=1, no valid; without macro -> valid, data_out=0x3700190051.
REQ-034 Bit high times of 26 us and 70 us -> decode 0 and 1 respectively; 41 us -> 1, 40 us -> 0.
REQ-035 rst asserted at bit 20 of a frame -> all outputs 0 next edge, no valid; subsequent start yields a correct frame.
REQ-036 start pulsed while busy -> ignored, frame completes normally with a single valid pulse.
